// File: rtl/booth_radix4_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : booth_radix4_encoder_seq
// Description : Sequential radix-4 Booth recoder for the FMAC multiplier path.
//               Accepts a signed two's-complement multiplier and emits one
//               3-bit action code per beat, least-significant group first,
//               for the downstream partial-product shifter
//               (0, +M, +2M, -M, -2M).
//
// Ports       :
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   multiplier operand valid
//   in_ready    out  encoder can accept an operand (never depends on in_valid)
//   multiplier  in   [WIDTH-1:0] signed multiplier, sampled only on accept
//   act_valid   out  action/group_idx/last valid
//   act_ready   in   downstream accepts the current action
//   action      out  [2:0] Booth action code
//                    0:zero 1:+M 2:+2M 3:-M 4:-2M 7:zero (5 and 6 unused)
//   group_idx   out  [IDX_W-1:0] group index i, partial-product weight 4^i
//   last        out  high on the final group (i == GROUPS-1)
//
// Revision    : 1.0  initial release
// ============================================================================
module booth_radix4_encoder_seq #(
  parameter  int WIDTH  = 8,
  localparam int GROUPS = WIDTH / 2,
  localparam int IDX_W  = $clog2(GROUPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] multiplier,
  output logic             act_valid,
  input  logic             act_ready,
  output logic [2:0]       action,
  output logic [IDX_W-1:0] group_idx,
  output logic             last
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter guard: odd or too-narrow widths would leave a
  // dangling half group and break the 4^i weighting.
  // --------------------------------------------------------------------------
  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
      $error("booth_radix4_encoder_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_EMIT = 1'b1;

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(GROUPS - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

  localparam logic [2:0] c_ACT_ZERO  = 3'd0;
  localparam logic [2:0] c_ACT_PM    = 3'd1;
  localparam logic [2:0] c_ACT_P2M   = 3'd2;
  localparam logic [2:0] c_ACT_NM    = 3'd3;
  localparam logic [2:0] c_ACT_N2M   = 3'd4;
  localparam logic [2:0] c_ACT_ZERO7 = 3'd7;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  // Operand with an implicit m[-1]=0 appended below the LSB, so the current
  // Booth triplet is always the low three bits.
  logic [WIDTH:0]   r_opnd;
  logic [IDX_W-1:0] r_group_idx;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic             w_emit;
  logic             w_last;
  logic             w_beat_done;
  logic [2:0]       w_triplet;
  logic [2:0]       w_action;
  logic [WIDTH:0]   w_load_opnd;
  logic [WIDTH:0]   w_shift_opnd;

  assign w_emit      = (r_state == c_EMIT);
  assign w_last      = w_emit && (r_group_idx == c_LAST_IDX);
  assign w_beat_done = w_emit && act_ready;
  assign w_triplet   = r_opnd[2:0];
  assign w_load_opnd = {multiplier, 1'b0};

  // Arithmetic shift by one group: replicate the sign so later triplets of a
  // negative operand still see ones above the original MSB.
  assign w_shift_opnd = {{2{r_opnd[WIDTH]}}, r_opnd[WIDTH:2]};

  // Booth recoding of {m[2i+1], m[2i], m[2i-1]}. All-ones keeps its own
  // code (7) so the shifter can distinguish it from a plain zero group.
  always_comb begin
    w_action = c_ACT_ZERO;
    case (w_triplet)
      3'b000:         w_action = c_ACT_ZERO;
      3'b001, 3'b010: w_action = c_ACT_PM;
      3'b011:         w_action = c_ACT_P2M;
      3'b100:         w_action = c_ACT_N2M;
      3'b101, 3'b110: w_action = c_ACT_NM;
      3'b111:         w_action = c_ACT_ZERO7;
      default:        w_action = c_ACT_ZERO;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, operand and group-index update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_opnd      <= '0;
      r_group_idx <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_opnd      <= w_load_opnd;
            r_group_idx <= '0;
            r_state     <= c_EMIT;
          end
        end
        c_EMIT: begin
          if (act_ready) begin
            if (!w_last) begin
              r_opnd      <= w_shift_opnd;
              r_group_idx <= r_group_idx + c_IDX_ONE;
            end else if (in_valid) begin
              // Zero-bubble reload: next operand's group 0 follows directly.
              r_opnd      <= w_load_opnd;
              r_group_idx <= '0;
            end else begin
              r_state     <= c_IDLE;
            end
          end
          // Without act_ready every register holds, keeping outputs stable.
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = !w_emit || (w_last && w_beat_done);
  assign act_valid = w_emit;
  assign action    = w_emit ? w_action : c_ACT_ZERO;
  assign group_idx = r_group_idx;
  assign last      = w_last;

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_radix4_encoder_seq
// Description : Directed self-checking bench for booth_radix4_encoder_seq
//               (WIDTH=8): reset, single operands, stalls, back-to-back,
//               mid-operation reset and a Booth-sum regression.
// Revision    : 1.0  initial release
// ============================================================================
module tb_booth_radix4_encoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] multiplier;
  logic       act_valid;
  logic       act_ready;
  logic [2:0] action;
  logic [1:0] group_idx;
  logic       last;

  int checks   = 0;
  int failures = 0;

  booth_radix4_encoder_seq #(.WIDTH(8)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .multiplier (multiplier),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .action     (action),
    .group_idx  (group_idx),
    .last       (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bval(input logic [2:0] a);
    case (a)
      3'd0, 3'd7: return 0;
      3'd1:       return 1;
      3'd2:       return 2;
      3'd3:       return -1;
      3'd4:       return -2;
      default:    return 1000;
    endcase
  endfunction

  // Present one operand with act_ready held high from IDLE and check all four
  // beats against hand-computed codes packed as {a3,a2,a1,a0}.
  task automatic run_operand(input logic [7:0] m, input logic [11:0] exp);
    act_ready  = 1'b1;
    in_valid   = 1'b1;
    multiplier = m;
    #1;
    chk("op_in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid   = 1'b0;
    multiplier = ~m;   // must be ignored after accept
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("op_valid",    act_valid, 1);
      chk("op_action",   action, exp[3*i +: 3]);
      chk("op_idx",      group_idx, i);
      chk("op_last",     last, (i == 3));
      chk("op_in_ready", in_ready, (i == 3));
      @(negedge clk);
      #1;
    end
    chk("op_drain", act_valid, 0);
  endtask

  initial begin
    int         hs;
    bit         have_prev;
    logic [2:0] p_action;
    logic [1:0] p_idx;
    logic       p_last;
    int         sum;
    bit         done;
    logic [7:0] m;

    // ---------------- reset with in_valid asserted ----------------
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    multiplier = 8'h07;
    act_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_act_valid", act_valid, 0);
    chk("rst_action",    action, 0);
    chk("rst_idx",       group_idx, 0);
    chk("rst_last",      last, 0);
    chk("rst_in_ready",  in_ready, 1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_no_beat",   act_valid, 0);
    chk("rst_in_ready2", in_ready, 1);

    // ---------------- single operands ----------------
    run_operand(8'h07, {3'd0, 3'd0, 3'd2, 3'd3});
    run_operand(8'hFF, {3'd7, 3'd7, 3'd7, 3'd3});
    run_operand(8'h80, {3'd4, 3'd0, 3'd0, 3'd0});
    run_operand(8'h00, {3'd0, 3'd0, 3'd0, 3'd0});

    // ---------------- 0x55 with stalls (ready 1,0,0,1,0,0,...) ----------------
    in_valid   = 1'b1;
    multiplier = 8'h55;
    act_ready  = 1'b0;
    #1;
    chk("stall_accept", in_ready, 1);
    @(negedge clk);
    in_valid  = 1'b0;
    hs        = 0;
    have_prev = 1'b0;
    p_action  = '0;
    p_idx     = '0;
    p_last    = 1'b0;
    for (int c = 0; c < 40 && hs < 4; c++) begin
      act_ready = ((c % 3) == 0);
      #1;
      if (have_prev) begin
        chk("stall_hold_valid",  act_valid, 1);
        chk("stall_hold_action", action, p_action);
        chk("stall_hold_idx",    group_idx, p_idx);
        chk("stall_hold_last",   last, p_last);
      end
      if (act_valid) begin
        chk("stall_action", action, 3'd1);
        chk("stall_idx",    group_idx, hs);
        if (act_ready) begin
          hs++;
          have_prev = 1'b0;
        end else begin
          p_action  = action;
          p_idx     = group_idx;
          p_last    = last;
          have_prev = 1'b1;
        end
      end
      @(negedge clk);
    end
    chk("stall_handshakes", hs, 4);
    act_ready = 1'b1;
    #1;
    chk("stall_drain", act_valid, 0);

    // ---------------- back-to-back 0x07 then 0x80 ----------------
    in_valid   = 1'b1;
    multiplier = 8'h07;
    act_ready  = 1'b1;
    #1;
    chk("b2b_accept0", in_ready, 1);
    @(negedge clk);
    multiplier = 8'h80;
    #1;
    begin
      logic [23:0] b2b_exp;
      b2b_exp = {3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd3};
      for (int i = 0; i < 8; i++) begin
        chk("b2b_valid",  act_valid, 1);
        chk("b2b_action", action, b2b_exp[3*i +: 3]);
        chk("b2b_idx",    group_idx, i % 4);
        chk("b2b_last",   last, ((i % 4) == 3));
        if (i == 3) chk("b2b_in_ready", in_ready, 1);
        @(negedge clk);
        if (i == 3) in_valid = 1'b0;
        #1;
      end
    end
    chk("b2b_drain", act_valid, 0);

    // ---------------- reset after beat 1 of 0x55 ----------------
    in_valid   = 1'b1;
    multiplier = 8'h55;
    act_ready  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_idx0", group_idx, 0);
    @(negedge clk);
    #1;
    chk("mid_idx1", group_idx, 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;   // reset must win over a concurrent operand
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_act_valid", act_valid, 0);
    chk("mid_in_ready",  in_ready, 1);
    chk("mid_idx",       group_idx, 0);
    chk("mid_last",      last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_no_beat", act_valid, 0);
    run_operand(8'h07, {3'd0, 3'd0, 3'd2, 3'd3});

    // ---------------- random Booth-sum regression ----------------
    for (int n = 0; n < 300; n++) begin
      m          = 8'($urandom);
      in_valid   = 1'b1;
      multiplier = m;
      act_ready  = 1'($urandom_range(0, 1));
      #1;
      chk("rnd_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      sum      = 0;
      done     = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        act_ready = 1'($urandom_range(0, 1));
        #1;
        if (act_valid) begin
          chk("rnd_code_legal", (action == 3'd5 || action == 3'd6), 0);
          if (act_ready) begin
            sum += bval(action) * (1 << (2 * int'(group_idx)));
            if (last) done = 1'b1;
          end
        end
        @(negedge clk);
      end
      chk("rnd_done", done, 1);
      chk("rnd_sum",  sum, int'($signed(m)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
